id_stage: RTL
=============

# id_stage

Parametrised successor of the combinational decode stage, for the LoongArch32 pipeline. It decodes the ALU instruction set from `define.v`, adding LU12I.W and PCADDU12I. Source operands are resolved through N forwarding sources with priority, and load-use hazards stall the stage. Results are registered in an ID/EX pipeline register under a valid/ready handshake with flush; the block sits between IF/ID and EX.

## Interface
- `FWD_NUM`, default 2: number of forwarding sources. Index 0 is the youngest producer (EX) and has the highest priority.
- `REG_ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `flush_i`  in  1  kill the instruction held in ID and the ID/EX register
- `valid_i`  in  1  `pc_i`/`inst_i` carry a real instruction
- `ready_o`  out  1  ID accepts the input this cycle
- `pc_i`  in  32  instruction PC
- `inst_i`  in  32  instruction word
- `reg1_read_addr_o`, `reg2_read_addr_o`  out  REG_ADDR_W  regfile read addresses (combinational); always rj and rk
- `reg1_read_en_o`, `reg2_read_en_o`  out  1  regfile read enables (combinational)
- `reg1_data_i`, `reg2_data_i`  in  DATA_W  regfile read data, same cycle
- `fwd_en_i`  in  FWD_NUM  forwarding source k will write
- `fwd_addr_i`  in  FWD_NUM*REG_ADDR_W  destination register of source k
- `fwd_data_i`  in  FWD_NUM*DATA_W  result of source k
- `fwd_pending_i`  in  FWD_NUM  source k's data is not yet valid (load in flight)
- `valid_o`  out  1  ID/EX register holds an instruction
- `ready_i`  in  1  EX accepts the ID/EX register
- `pc_o`  out  32  registered PC
- `aluop_o`  out  ALUOpWidth  registered ALU op
- `alusel_o`  out  ALUSelWidth  registered ALU select
- `reg1_o`, `reg2_o`  out  DATA_W  registered operands
- `reg_write_addr_o`  out  REG_ADDR_W  registered destination register
- `reg_write_en_o`  out  1  registered write enable
- `inst_valid_o`  out  1  0 means illegal instruction (EX raises INE)
- `pause_id_o`  out  1  load-use stall active (combinational)

## Operation
- **Decode set:** the decode table is unchanged for ADD.W, SUB.W, SLT, SLTU, NOR, AND, OR, XOR, SLL.W, SRL.W, SRA.W, MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU, MOD.WU, SLLI.W, SRLI.W, SRAI.W, SLTI, SLTUI, ADDI.W, ANDI, ORI, XORI.
- **New ops:** LU12I.W (`inst[31:25]=0001010`) and PCADDU12I (`0001110`). Both use imm = {si20, 12'b0}, with new `ALU_LU12I`/`ALU_PCADDU12I` entries added to `define.v`.
- **Immediates:**
  - si12 is sign-extended for SLTI, SLTUI and ADDI.W.
  - ui12 is zero-extended for ANDI, ORI and XORI.
  - ui5 is zero-extended for the shift-immediate ops.
- **Operand mux:**
  - reg2_o = imm when rk is not read.
  - reg1_o = pc_i for PCADDU12I, and 0 for LU12I.W.
  - Any operand that is not read and not otherwise defined above is 0.
- **r0:** a read of r0 yields 0 regardless of regfile or forwarding data. rd=0 forces reg_write_en_o=0.
- **Forwarding:** for each read source, pick the lowest k with `fwd_en_i[k]` set and `fwd_addr_i[k]` equal to the source, non-zero address only.
  - If that k has `fwd_pending_i[k]=0`, the operand is `fwd_data_i[k]`.
  - If it has `fwd_pending_i[k]=1`, it is a hazard.
  - If no source matches, the operand is the regfile data.
  - A pending entry shadowed by a lower-k non-pending match is not a hazard.
- **Illegal instruction:** inst_valid=0, aluop=ALU_NOP, alusel=ALU_SEL_NOP, no reads, no write. The instruction still passes to EX with valid_o=1 and inst_valid_o=0.
- **Handshake:**
  - hazard = valid_i & (a pending match on any enabled read).
  - pause_id_o = hazard.
  - ready_o = (!valid_o | ready_i) & !hazard & !flush_i.
  - ID/EX update:
    - If flush_i: valid_o <= 0.
    - Else if ready_o & valid_i: load all decoded fields, valid_o <= 1.
    - Else if ready_i: valid_o <= 0, inserting a bubble.
    - Else: hold.

## Timing
- Reset:
  - All registered outputs are 0, with aluop_o=ALU_NOP and alusel_o=ALU_SEL_NOP.
  - pc_o, reg1_o and reg2_o are 0.
  - ready_o=0 while rst=1.
- Latency: an instruction accepted in cycle t appears on the outputs in t+1.
- Stall release: the stall clears in the cycle `fwd_pending_i` drops. The forwarded data is captured at that edge.
- flush_i priority: flush_i wins over accept and hold. A flush during a hazard clears the bubble, and ready_o stays 0 that cycle.
- Downstream hold: while ready_i=0 and valid_o=1, all outputs are held stable.
- Combinational paths: regfile read ports and pause_id_o are combinational from inst_i and the fwd inputs. No combinational path exists from ready_i to valid_o.

## Test plan
- **ADDI.W:** reset, then 0x02BFFC41 (ADDI.W r1,r2,-1) with reg1_data_i=5, ready_i=1.
  - Required next cycle: valid_o=1, reg1_o=5, reg2_o=0xFFFFFFFF, aluop_o=ALU_ADDIW, reg_write_addr_o=1, reg_write_en_o=1.
- **LU12I.W / PCADDU12I:**
  - 0x142468A3 (LU12I.W r3,0x12345) requires reg2_o=0x12345000, reg1_o=0.
  - PCADDU12I with pc_i=0x1C000010 requires reg1_o=0x1C000010.
- **Forwarding priority:** ADD.W rd,r4,r5 with fwd0 writing r4=0xAA and fwd1 writing r4=0xBB, r5=0xCC.
  - Required: reg1_o=0xAA, reg2_o=0xCC. The same case with source r0 gives 0.
- **Load-use:** fwd0 writes r4 with pending=1 for 2 cycles.
  - Required: pause_id_o=1 and ready_o=0 for 2 cycles, valid_o=0 bubbles, then the load data is captured and valid_o=1.
- **Back-pressure / flush:** ready_i=0 for 3 cycles holds the outputs. flush_i asserted then gives valid_o=0 next cycle.
- **Illegal instruction:** inst_i=0xFFFFFFFF gives valid_o=1, inst_valid_o=0, reg_write_en_o=0, aluop_o=ALU_NOP.

Source files
------------

// File: rtl/id_stage.sv
// Purpose: LoongArch32 decode stage that resolves operands through prioritised forwarding and registers results into ID/EX.
// Latency: one cycle from acceptance to valid_o. Regfile read ports and pause_id_o are combinational.
// Backpressure: ready_o drops on a load-use hazard, on flush, or while a full ID/EX register waits on ready_i.
module id_stage #(
    parameter int  FWD_NUM     = 2,
    parameter int  REG_ADDR_W  = 5,
    parameter int  DATA_W      = 32,
    localparam int ALUOpWidth  = 8,
    localparam int ALUSelWidth = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [31:0]                   pc_i,
    input  logic [31:0]                   inst_i,
    output logic [REG_ADDR_W-1:0]         reg1_read_addr_o,
    output logic [REG_ADDR_W-1:0]         reg2_read_addr_o,
    output logic                          reg1_read_en_o,
    output logic                          reg2_read_en_o,
    input  logic [DATA_W-1:0]             reg1_data_i,
    input  logic [DATA_W-1:0]             reg2_data_i,
    input  logic [FWD_NUM-1:0]            fwd_en_i,
    input  logic [FWD_NUM*REG_ADDR_W-1:0] fwd_addr_i,
    input  logic [FWD_NUM*DATA_W-1:0]     fwd_data_i,
    input  logic [FWD_NUM-1:0]            fwd_pending_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [31:0]                   pc_o,
    output logic [ALUOpWidth-1:0]         aluop_o,
    output logic [ALUSelWidth-1:0]        alusel_o,
    output logic [DATA_W-1:0]             reg1_o,
    output logic [DATA_W-1:0]             reg2_o,
    output logic [REG_ADDR_W-1:0]         reg_write_addr_o,
    output logic                          reg_write_en_o,
    output logic                          inst_valid_o,
    output logic                          pause_id_o
);

    // ALU operation codes shared with EX
    localparam logic [ALUOpWidth-1:0] ALU_NOP       = 8'h00;
    localparam logic [ALUOpWidth-1:0] ALU_ADDW      = 8'h01;
    localparam logic [ALUOpWidth-1:0] ALU_SUBW      = 8'h02;
    localparam logic [ALUOpWidth-1:0] ALU_SLT       = 8'h03;
    localparam logic [ALUOpWidth-1:0] ALU_SLTU      = 8'h04;
    localparam logic [ALUOpWidth-1:0] ALU_NOR       = 8'h05;
    localparam logic [ALUOpWidth-1:0] ALU_AND       = 8'h06;
    localparam logic [ALUOpWidth-1:0] ALU_OR        = 8'h07;
    localparam logic [ALUOpWidth-1:0] ALU_XOR       = 8'h08;
    localparam logic [ALUOpWidth-1:0] ALU_SLLW      = 8'h09;
    localparam logic [ALUOpWidth-1:0] ALU_SRLW      = 8'h0A;
    localparam logic [ALUOpWidth-1:0] ALU_SRAW      = 8'h0B;
    localparam logic [ALUOpWidth-1:0] ALU_MULW      = 8'h0C;
    localparam logic [ALUOpWidth-1:0] ALU_MULHW     = 8'h0D;
    localparam logic [ALUOpWidth-1:0] ALU_MULHWU    = 8'h0E;
    localparam logic [ALUOpWidth-1:0] ALU_DIVW      = 8'h0F;
    localparam logic [ALUOpWidth-1:0] ALU_MODW      = 8'h10;
    localparam logic [ALUOpWidth-1:0] ALU_DIVWU     = 8'h11;
    localparam logic [ALUOpWidth-1:0] ALU_MODWU     = 8'h12;
    localparam logic [ALUOpWidth-1:0] ALU_SLLIW     = 8'h13;
    localparam logic [ALUOpWidth-1:0] ALU_SRLIW     = 8'h14;
    localparam logic [ALUOpWidth-1:0] ALU_SRAIW     = 8'h15;
    localparam logic [ALUOpWidth-1:0] ALU_SLTI      = 8'h16;
    localparam logic [ALUOpWidth-1:0] ALU_SLTUI     = 8'h17;
    localparam logic [ALUOpWidth-1:0] ALU_ADDIW     = 8'h18;
    localparam logic [ALUOpWidth-1:0] ALU_ANDI      = 8'h19;
    localparam logic [ALUOpWidth-1:0] ALU_ORI       = 8'h1A;
    localparam logic [ALUOpWidth-1:0] ALU_XORI      = 8'h1B;
    localparam logic [ALUOpWidth-1:0] ALU_LU12I     = 8'h1C;
    localparam logic [ALUOpWidth-1:0] ALU_PCADDU12I = 8'h1D;

    localparam logic [ALUSelWidth-1:0] ALU_SEL_NOP   = 3'd0;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_LOGIC = 3'd1;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_SHIFT = 3'd2;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_ARITH = 3'd3;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_MUL   = 3'd4;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_DIV   = 3'd5;

    // Operand/immediate formats; the format alone decides which ports are read
    typedef enum logic [2:0] {
        FMT_NONE, FMT_3R, FMT_UI5, FMT_SI12, FMT_UI12, FMT_SI20
    } fmt_t;

    logic [REG_ADDR_W-1:0]  rj, rk, rd;
    fmt_t                   dec_fmt;
    logic [ALUOpWidth-1:0]  dec_op;
    logic [ALUSelWidth-1:0] dec_sel;
    logic                   dec_legal, dec_rd1, dec_rd2;
    logic [31:0]            dec_imm;
    logic [DATA_W-1:0]      op1_val, op2_val, op1_fin, op2_fin;
    logic                   op1_haz, op2_haz, hazard;

    assign rj = REG_ADDR_W'(inst_i[9:5]);
    assign rk = REG_ADDR_W'(inst_i[14:10]);
    assign rd = REG_ADDR_W'(inst_i[4:0]);

    // Opcode decode: pick ALU op, unit select and operand format
    always_comb begin
        dec_fmt = FMT_NONE;
        dec_op  = ALU_NOP;
        dec_sel = ALU_SEL_NOP;
        case (inst_i[31:22])
            10'h000: begin
                dec_fmt = FMT_3R;
                case (inst_i[21:15])
                    7'h20: begin dec_op = ALU_ADDW;   dec_sel = ALU_SEL_ARITH; end
                    7'h22: begin dec_op = ALU_SUBW;   dec_sel = ALU_SEL_ARITH; end
                    7'h24: begin dec_op = ALU_SLT;    dec_sel = ALU_SEL_ARITH; end
                    7'h25: begin dec_op = ALU_SLTU;   dec_sel = ALU_SEL_ARITH; end
                    7'h28: begin dec_op = ALU_NOR;    dec_sel = ALU_SEL_LOGIC; end
                    7'h29: begin dec_op = ALU_AND;    dec_sel = ALU_SEL_LOGIC; end
                    7'h2A: begin dec_op = ALU_OR;     dec_sel = ALU_SEL_LOGIC; end
                    7'h2B: begin dec_op = ALU_XOR;    dec_sel = ALU_SEL_LOGIC; end
                    7'h2E: begin dec_op = ALU_SLLW;   dec_sel = ALU_SEL_SHIFT; end
                    7'h2F: begin dec_op = ALU_SRLW;   dec_sel = ALU_SEL_SHIFT; end
                    7'h30: begin dec_op = ALU_SRAW;   dec_sel = ALU_SEL_SHIFT; end
                    7'h38: begin dec_op = ALU_MULW;   dec_sel = ALU_SEL_MUL;   end
                    7'h39: begin dec_op = ALU_MULHW;  dec_sel = ALU_SEL_MUL;   end
                    7'h3A: begin dec_op = ALU_MULHWU; dec_sel = ALU_SEL_MUL;   end
                    7'h40: begin dec_op = ALU_DIVW;   dec_sel = ALU_SEL_DIV;   end
                    7'h41: begin dec_op = ALU_MODW;   dec_sel = ALU_SEL_DIV;   end
                    7'h42: begin dec_op = ALU_DIVWU;  dec_sel = ALU_SEL_DIV;   end
                    7'h43: begin dec_op = ALU_MODWU;  dec_sel = ALU_SEL_DIV;   end
                    default: dec_fmt = FMT_NONE;
                endcase
            end
            10'h001: begin
                dec_fmt = FMT_UI5;
                dec_sel = ALU_SEL_SHIFT;
                case (inst_i[21:15])
                    7'h01:   dec_op = ALU_SLLIW;
                    7'h09:   dec_op = ALU_SRLIW;
                    7'h11:   dec_op = ALU_SRAIW;
                    default: begin dec_fmt = FMT_NONE; dec_sel = ALU_SEL_NOP; end
                endcase
            end
            10'h008: begin dec_fmt = FMT_SI12; dec_op = ALU_SLTI;  dec_sel = ALU_SEL_ARITH; end
            10'h009: begin dec_fmt = FMT_SI12; dec_op = ALU_SLTUI; dec_sel = ALU_SEL_ARITH; end
            10'h00A: begin dec_fmt = FMT_SI12; dec_op = ALU_ADDIW; dec_sel = ALU_SEL_ARITH; end
            10'h00D: begin dec_fmt = FMT_UI12; dec_op = ALU_ANDI;  dec_sel = ALU_SEL_LOGIC; end
            10'h00E: begin dec_fmt = FMT_UI12; dec_op = ALU_ORI;   dec_sel = ALU_SEL_LOGIC; end
            10'h00F: begin dec_fmt = FMT_UI12; dec_op = ALU_XORI;  dec_sel = ALU_SEL_LOGIC; end
            default: begin
                case (inst_i[31:25])
                    7'b0001010: begin dec_fmt = FMT_SI20; dec_op = ALU_LU12I;     dec_sel = ALU_SEL_ARITH; end
                    7'b0001110: begin dec_fmt = FMT_SI20; dec_op = ALU_PCADDU12I; dec_sel = ALU_SEL_ARITH; end
                    default:    dec_fmt = FMT_NONE;
                endcase
            end
        endcase
    end

    // Format to read enables and immediate
    always_comb begin
        dec_legal = (dec_fmt != FMT_NONE);
        dec_rd1   = (dec_fmt == FMT_3R) || (dec_fmt == FMT_UI5) ||
                    (dec_fmt == FMT_SI12) || (dec_fmt == FMT_UI12);
        dec_rd2   = (dec_fmt == FMT_3R);
        case (dec_fmt)
            FMT_UI5:  dec_imm = {27'b0, inst_i[14:10]};
            FMT_SI12: dec_imm = {{20{inst_i[21]}}, inst_i[21:10]};
            FMT_UI12: dec_imm = {20'b0, inst_i[21:10]};
            FMT_SI20: dec_imm = {inst_i[24:5], 12'b0};
            default:  dec_imm = 32'b0;
        endcase
    end

    assign reg1_read_addr_o = rj;
    assign reg2_read_addr_o = rk;
    assign reg1_read_en_o   = dec_rd1;
    assign reg2_read_en_o   = dec_rd2;

    // Forwarding: scan oldest to youngest so the lowest matching index wins
    always_comb begin
        op1_val = reg1_data_i;
        op2_val = reg2_data_i;
        op1_haz = 1'b0;
        op2_haz = 1'b0;
        for (int k = FWD_NUM - 1; k >= 0; k--) begin
            if (fwd_en_i[k] && fwd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == rj) begin
                op1_haz = fwd_pending_i[k];
                op1_val = fwd_pending_i[k] ? reg1_data_i : fwd_data_i[k*DATA_W +: DATA_W];
            end
            if (fwd_en_i[k] && fwd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == rk) begin
                op2_haz = fwd_pending_i[k];
                op2_val = fwd_pending_i[k] ? reg2_data_i : fwd_data_i[k*DATA_W +: DATA_W];
            end
        end
        // r0 is hard-wired to zero and never waits on a producer
        if (rj == '0) begin
            op1_val = '0;
            op1_haz = 1'b0;
        end
        if (rk == '0) begin
            op2_val = '0;
            op2_haz = 1'b0;
        end
    end

    // Final operand mux: PC for PCADDU12I, immediate replaces an unread rk
    always_comb begin
        if (dec_rd1)                      op1_fin = op1_val;
        else if (dec_op == ALU_PCADDU12I) op1_fin = DATA_W'(pc_i);
        else                              op1_fin = '0;
        op2_fin = dec_rd2 ? op2_val : DATA_W'(dec_imm);
    end

    assign hazard     = valid_i & ((dec_rd1 & op1_haz) | (dec_rd2 & op2_haz));
    assign pause_id_o = hazard;
    assign ready_o    = !rst && (!valid_o || ready_i) && !hazard && !flush_i;

    // ID/EX register: flush beats accept, accept beats bubble, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o          <= 1'b0;
            pc_o             <= '0;
            aluop_o          <= ALU_NOP;
            alusel_o         <= ALU_SEL_NOP;
            reg1_o           <= '0;
            reg2_o           <= '0;
            reg_write_addr_o <= '0;
            reg_write_en_o   <= 1'b0;
            inst_valid_o     <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (ready_o && valid_i) begin
            valid_o          <= 1'b1;
            pc_o             <= pc_i;
            aluop_o          <= dec_op;
            alusel_o         <= dec_sel;
            reg1_o           <= op1_fin;
            reg2_o           <= op2_fin;
            reg_write_addr_o <= dec_legal ? rd : '0;
            reg_write_en_o   <= dec_legal && (rd != '0);
            inst_valid_o     <= dec_legal;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
